// File: rtl/gemac_wb_regs.sv
// GEMAC Wishbone register file and MDIO management master.
// Static filter/pause settings feed the MAC core; MDIO frames are serialised on mdc/mdio_o.
module gemac_wb_regs #(
    parameter logic [7:0] MDIO_DIV_RST = 8'd100
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    input  logic        wb_we,
    input  logic [7:0]  wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic [6:0]  misc_settings,
    output logic [47:0] ucast_addr,
    output logic [47:0] mcast_addr,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_HDR, ST_TA, ST_DATA} state_t;

    localparam logic [5:0] A_MISC    = 6'h00;
    localparam logic [5:0] A_UCAST_H = 6'h01;
    localparam logic [5:0] A_UCAST_L = 6'h02;
    localparam logic [5:0] A_MCAST_H = 6'h03;
    localparam logic [5:0] A_MCAST_L = 6'h04;
    localparam logic [5:0] A_MDIO_CF = 6'h05;
    localparam logic [5:0] A_MDIO_AD = 6'h06;
    localparam logic [5:0] A_MDIO_CM = 6'h07;
    localparam logic [5:0] A_WDATA   = 6'h08;
    localparam logic [5:0] A_RDATA   = 6'h09;
    localparam logic [5:0] A_BUSY    = 6'h0A;

    logic        ack_q, ack_d;
    logic [31:0] dat_o_q, dat_o_d;
    logic [6:0]  misc_q, misc_d;
    logic [15:0] ucast_h_q, ucast_h_d;
    logic [31:0] ucast_l_q, ucast_l_d;
    logic [15:0] mcast_h_q, mcast_h_d;
    logic [31:0] mcast_l_q, mcast_l_d;
    logic        nopre_q, nopre_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [4:0]  phy_addr_q, phy_addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    state_t      state_q, state_d;
    logic        mdc_q, mdc_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [7:0]  d_lat_q, d_lat_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [63:0] sr_q, sr_d;
    logic [15:0] rx_q, rx_d;
    logic        is_read_q, is_read_d;

    logic        acc, wr, busy, tick, rise, fall;
    logic        cmd_rd, cmd_wr, start;
    logic [5:0]  word_adr;
    logic [31:0] rd_val;
    logic [63:0] frame, frame_sel;
    logic [7:0]  d_eff;
    logic [6:0]  nxt_cnt;
    logic        unused_adr;

    assign word_adr   = wb_adr[7:2];
    assign unused_adr = ^wb_adr[1:0];
    assign acc        = wb_stb & wb_cyc & ~ack_q;
    assign wr         = acc & wb_we;
    assign busy       = (state_q != ST_IDLE);

    // A command is only taken while idle; the read bit wins when both are set.
    assign cmd_rd = wr && (word_adr == A_MDIO_CM) && !busy && wb_dat_i[0];
    assign cmd_wr = wr && (word_adr == A_MDIO_CM) && !busy && !wb_dat_i[0] && wb_dat_i[1];
    assign start  = cmd_rd | cmd_wr;

    assign frame = {32'hFFFF_FFFF, 2'b01, (cmd_rd ? 2'b10 : 2'b01), phy_addr_q, reg_addr_q,
                    (cmd_rd ? 2'b00 : 2'b10), (cmd_rd ? 16'h0000 : wdata_q)};
    assign frame_sel = nopre_q ? {frame[31:0], 32'h0000_0000} : frame;
    assign d_eff     = (div_q < 8'd2) ? 8'd2 : div_q;

    assign tick    = (div_cnt_q == (d_lat_q - 8'd1));
    assign rise    = busy && tick && !mdc_q;
    assign fall    = busy && tick && mdc_q;
    assign nxt_cnt = bit_cnt_q - 7'd1;

    always_comb begin
        rd_val = 32'h0;
        case (word_adr)
            A_MISC:    rd_val = {25'h0, misc_q};
            A_UCAST_H: rd_val = {16'h0, ucast_h_q};
            A_UCAST_L: rd_val = ucast_l_q;
            A_MCAST_H: rd_val = {16'h0, mcast_h_q};
            A_MCAST_L: rd_val = mcast_l_q;
            A_MDIO_CF: rd_val = {23'h0, nopre_q, div_q};
            A_MDIO_AD: rd_val = {19'h0, reg_addr_q, 3'b000, phy_addr_q};
            A_WDATA:   rd_val = {16'h0, wdata_q};
            A_RDATA:   rd_val = {16'h0, rdata_q};
            A_BUSY:    rd_val = {31'h0, busy};
            default:   rd_val = 32'h0;
        endcase
    end

    always_comb begin
        ack_d      = acc;
        dat_o_d    = acc ? rd_val : dat_o_q;
        misc_d     = misc_q;
        ucast_h_d  = ucast_h_q;
        ucast_l_d  = ucast_l_q;
        mcast_h_d  = mcast_h_q;
        mcast_l_d  = mcast_l_q;
        nopre_d    = nopre_q;
        div_d      = div_q;
        reg_addr_d = reg_addr_q;
        phy_addr_d = phy_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        state_d    = state_q;
        mdc_d      = mdc_q;
        mdio_o_d   = mdio_o_q;
        mdio_oe_d  = mdio_oe_q;
        div_cnt_d  = div_cnt_q;
        d_lat_d    = d_lat_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        rx_d       = rx_q;
        is_read_d  = is_read_q;

        if (wr) begin
            case (word_adr)
                A_MISC:    misc_d    = wb_dat_i[6:0];
                A_UCAST_H: ucast_h_d = wb_dat_i[15:0];
                A_UCAST_L: ucast_l_d = wb_dat_i;
                A_MCAST_H: mcast_h_d = wb_dat_i[15:0];
                A_MCAST_L: mcast_l_d = wb_dat_i;
                A_MDIO_CF: begin
                    nopre_d = wb_dat_i[8];
                    div_d   = wb_dat_i[7:0];
                end
                A_MDIO_AD: begin
                    reg_addr_d = wb_dat_i[12:8];
                    phy_addr_d = wb_dat_i[4:0];
                end
                A_WDATA:   wdata_d = wb_dat_i[15:0];
                default:   ;
            endcase
        end

        // Outgoing bits change on mdc falling edges; incoming bits are taken on rising edges.
        if (busy) begin
            div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
            if (tick) mdc_d = ~mdc_q;
            if (rise && (state_q == ST_DATA) && is_read_q) rx_d = {rx_q[14:0], mdio_i};
            if (fall) begin
                if (bit_cnt_q == 7'd1) begin
                    state_d   = ST_IDLE;
                    mdio_oe_d = 1'b0;
                    mdio_o_d  = 1'b0;
                    mdc_d     = 1'b0;
                    div_cnt_d = 8'd0;
                    if (is_read_q) rdata_d = rx_q;
                end else begin
                    bit_cnt_d = nxt_cnt;
                    mdio_o_d  = sr_q[63];
                    sr_d      = {sr_q[62:0], 1'b0};
                    mdio_oe_d = ~(is_read_q && (nxt_cnt <= 7'd18));
                    if (nxt_cnt > 7'd32)      state_d = ST_PRE;
                    else if (nxt_cnt > 7'd18) state_d = ST_HDR;
                    else if (nxt_cnt > 7'd16) state_d = ST_TA;
                    else                      state_d = ST_DATA;
                end
            end
        end

        // The accept edge acts as the first falling edge of the frame.
        if (start) begin
            state_d   = nopre_q ? ST_HDR : ST_PRE;
            bit_cnt_d = nopre_q ? 7'd32 : 7'd64;
            mdio_o_d  = frame_sel[63];
            sr_d      = {frame_sel[62:0], 1'b0};
            mdio_oe_d = 1'b1;
            mdc_d     = 1'b0;
            div_cnt_d = 8'd0;
            d_lat_d   = d_eff;
            is_read_d = cmd_rd;
            rx_d      = 16'h0;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q      <= 1'b0;
            dat_o_q    <= '0;
            misc_q     <= '0;
            ucast_h_q  <= '0;
            ucast_l_q  <= '0;
            mcast_h_q  <= '0;
            mcast_l_q  <= '0;
            nopre_q    <= 1'b0;
            div_q      <= MDIO_DIV_RST;
            reg_addr_q <= '0;
            phy_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            state_q    <= ST_IDLE;
            mdc_q      <= 1'b0;
            mdio_o_q   <= 1'b0;
            mdio_oe_q  <= 1'b0;
            div_cnt_q  <= '0;
            d_lat_q    <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            rx_q       <= '0;
            is_read_q  <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_o_q    <= dat_o_d;
            misc_q     <= misc_d;
            ucast_h_q  <= ucast_h_d;
            ucast_l_q  <= ucast_l_d;
            mcast_h_q  <= mcast_h_d;
            mcast_l_q  <= mcast_l_d;
            nopre_q    <= nopre_d;
            div_q      <= div_d;
            reg_addr_q <= reg_addr_d;
            phy_addr_q <= phy_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            mdc_q      <= mdc_d;
            mdio_o_q   <= mdio_o_d;
            mdio_oe_q  <= mdio_oe_d;
            div_cnt_q  <= div_cnt_d;
            d_lat_q    <= d_lat_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            rx_q       <= rx_d;
            is_read_q  <= is_read_d;
        end
    end

    assign wb_ack        = ack_q;
    assign wb_dat_o      = dat_o_q;
    assign misc_settings = misc_q;
    assign ucast_addr    = {ucast_h_q, ucast_l_q};
    assign mcast_addr    = {mcast_h_q, mcast_l_q};
    assign mdc           = mdc_q;
    assign mdio_o        = mdio_o_q;
    assign mdio_oe       = mdio_oe_q;

endmodule

// File: tb/tb_gemac_wb_regs.sv
// Bench for gemac_wb_regs: bus reads and MDIO bits are checked by scoreboard monitors
// fed from hand-computed expected values pushed by the stimulus process.
module tb_gemac_wb_regs;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_we = 1'b0;
    logic [7:0]  wb_adr = 8'h00;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic [6:0]  misc_settings;
    logic [47:0] ucast_addr;
    logic [47:0] mcast_addr;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b0;

    gemac_wb_regs #(.MDIO_DIV_RST(8'd100)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
        .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack), .misc_settings(misc_settings), .ucast_addr(ucast_addr),
        .mcast_addr(mcast_addr), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .mdio_i(mdio_i)
    );

    always #5 wb_clk = ~wb_clk;

    int checks = 0;
    int errors = 0;

    bit          sb_rd[$];
    logic [31:0] sb_exp[$];
    string       sb_name[$];
    bit          mq_oe[$];
    bit          mq_o[$];

    int last_acc = 0;
    int exp_first = 0;
    int exp_period = 0;
    int last_rise = 0;
    bit frame_first = 1'b0;

    // Posedge k of wb_clk falls at time 10k-5, so this gives the edge count at either clock phase.
    function automatic int now_cyc();
        return int'(($time + 5) / 10);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input bit we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [31:0] exp, input string name);
        @(negedge wb_clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        sb_rd.push_back(!we);
        sb_exp.push_back(exp);
        sb_name.push_back(name);
        @(negedge wb_clk);
        last_acc = now_cyc();
        check($sformatf("%s_ack", name), wb_ack, 1'b1);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
        bus(1'b1, adr, dat, 32'h0, $sformatf("wr_%02h", adr));
    endtask

    task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 0, exp, name);
    endtask

    task automatic wait_until(input int acc_edge);
        while (now_cyc() < acc_edge - 2) @(negedge wb_clk);
    endtask

    task automatic push_frame(input logic [63:0] bits, input int nbits, input int n_oe);
        for (int i = 0; i < nbits; i++) begin
            mq_oe.push_back(i < n_oe);
            mq_o.push_back(bits[63 - i]);
        end
    endtask

    task automatic arm_frame(input int d);
        exp_first   = last_acc + d;
        exp_period  = 2 * d;
        frame_first = 1'b1;
    endtask

    task automatic phy_drive(input logic [15:0] val);
        for (int n = 1; n <= 31; n++) begin
            @(negedge mdc);
            if (n >= 16) mdio_i = val[31 - n];
        end
        @(negedge mdc);
        mdio_i = 1'b0;
    endtask

    // Bus monitor: every ack consumes one scoreboard entry; read entries compare data.
    always @(negedge wb_clk) begin : bus_mon
        bit          r;
        logic [31:0] e;
        string       n;
        if (wb_ack) begin
            if (sb_rd.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_ack: got ack, expected none");
            end else begin
                r = sb_rd.pop_front();
                e = sb_exp.pop_front();
                n = sb_name.pop_front();
                if (r) check(n, wb_dat_o, e);
            end
        end
    end

    // MDIO monitor: the PHY view, one expected bit per mdc rising edge.
    always @(posedge mdc) begin : mdio_mon
        int c;
        bit eo, ev;
        c = now_cyc();
        if (mq_oe.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL mdc_unexpected: got mdc rise at cycle %0d, expected none", c);
        end else begin
            eo = mq_oe.pop_front();
            ev = mq_o.pop_front();
            check("mdio_oe", mdio_oe, eo);
            if (eo) check("mdio_o", mdio_o, ev);
            if (frame_first) check("mdc_first_rise", c, exp_first);
            else             check("mdc_period", c - last_rise, exp_period);
            frame_first = 1'b0;
            last_rise   = c;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int e;
        repeat (3) @(negedge wb_clk);
        check("rst_mdc", mdc, 1'b0);
        check("rst_oe", mdio_oe, 1'b0);
        check("rst_mdio_o", mdio_o, 1'b0);
        check("rst_ack", wb_ack, 1'b0);
        check("rst_dat_o", wb_dat_o, 32'h0);
        wb_rst_n = 1'b1;

        // Reset values of the whole map
        for (int a = 0; a <= 8'h28; a += 4)
            rd(8'(a), (a == 8'h14) ? 32'h64 : 32'h0, $sformatf("rst_rd_%02h", a));
        @(negedge wb_clk);
        check("ack_single_cycle", wb_ack, 1'b0);

        // Register read-back and static outputs
        wr(8'h00, 32'hFFFF_FFBD);
        wr(8'h04, 32'hFFFF_A0B0);
        wr(8'h08, 32'hC0D0_A1B1);
        wr(8'h0C, 32'h0000_1357);
        wr(8'h10, 32'h2468_ACE0);
        rd(8'h00, 32'h3D, "rd_misc");
        rd(8'h04, 32'hA0B0, "rd_ucast_h");
        rd(8'h08, 32'hC0D0_A1B1, "rd_ucast_l");
        rd(8'h0C, 32'h1357, "rd_mcast_h");
        rd(8'h10, 32'h2468_ACE0, "rd_mcast_l");
        check("misc_settings", misc_settings, 7'h3D);
        check("ucast_addr", ucast_addr, 48'hA0B0_C0D0_A1B1);
        check("mcast_addr", mcast_addr, 48'h1357_2468_ACE0);
        wr(8'h3C, 32'hFFFF_FFFF);
        rd(8'h3C, 32'h0, "rd_unmapped");
        wr(8'h24, 32'h0000_FFFF);
        rd(8'h24, 32'h0, "rd_rdata_ro");
        wr(8'h1C, 32'h0);
        rd(8'h28, 32'h0, "busy_after_null_cmd");
        check("misc_after_unmapped", misc_settings, 7'h3D);
        check("ucast_after_unmapped", ucast_addr, 48'hA0B0_C0D0_A1B1);

        // Write frame, div=2, with preamble
        wr(8'h14, 32'h002);
        wr(8'h18, 32'h0001);
        wr(8'h20, 32'h1234);
        rd(8'h18, 32'h0001, "rd_mdio_addr");
        push_frame(64'hFFFF_FFFF_5082_1234, 64, 64);
        wr(8'h1C, 32'h2);
        arm_frame(2);
        e = last_acc;
        wait_until(e + 256);
        rd(8'h28, 32'h1, "t3_busy_last");
        rd(8'h28, 32'h0, "t3_busy_done");
        check("t3_oe_after", mdio_oe, 1'b0);
        check("t3_bits_left", mq_oe.size(), 0);

        // Read frame, div=8, no preamble, PHY returns 0xBEEF
        wr(8'h14, 32'h108);
        wr(8'h18, 32'h0A11);
        push_frame({14'b01101000101010, 50'b0}, 32, 14);
        fork
            phy_drive(16'hBEEF);
        join_none
        wr(8'h1C, 32'h1);
        arm_frame(8);
        e = last_acc;
        wait_until(e + 511);
        rd(8'h28, 32'h1, "t4_busy_late");
        rd(8'h28, 32'h0, "t4_busy_done");
        rd(8'h24, 32'hBEEF, "t4_rdata");
        check("t4_oe_after", mdio_oe, 1'b0);
        check("t4_bits_left", mq_oe.size(), 0);

        // Command and config writes while busy
        wr(8'h14, 32'h102);
        wr(8'h18, 32'h151F);
        wr(8'h20, 32'hA5C3);
        push_frame({32'h5FD6_A5C3, 32'h0}, 32, 32);
        wr(8'h1C, 32'h2);
        arm_frame(2);
        e = last_acc;
        wr(8'h20, 32'hFFFF);
        wr(8'h1C, 32'h2);
        wr(8'h14, 32'h103);
        wait_until(e + 127);
        rd(8'h28, 32'h1, "t5_busy_late");
        rd(8'h28, 32'h0, "t5_busy_done");
        rd(8'h14, 32'h103, "t5_div_updated");
        rd(8'h20, 32'hFFFF, "t5_wdata_updated");
        repeat (30) @(negedge wb_clk);
        check("t5_bits_left", mq_oe.size(), 0);

        // Reset during the data phase of a d=3 frame
        push_frame({32'h5FD6_FFFF, 32'h0}, 32, 32);
        wr(8'h1C, 32'h2);
        arm_frame(3);
        e = last_acc;
        while (now_cyc() < e + 130) @(negedge wb_clk);
        wb_rst_n = 1'b0;
        #1;
        check("t6_rst_mdc", mdc, 1'b0);
        check("t6_rst_oe", mdio_oe, 1'b0);
        check("t6_rst_mdio_o", mdio_o, 1'b0);
        mq_oe.delete();
        mq_o.delete();
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        rd(8'h28, 32'h0, "t6_busy_rst");
        rd(8'h14, 32'h64, "t6_div_rst");
        rd(8'h24, 32'h0, "t6_rdata_rst");
        rd(8'h20, 32'h0, "t6_wdata_rst");
        rd(8'h18, 32'h0, "t6_addr_rst");
        check("t6_misc_rst", misc_settings, 7'h00);
        check("t6_ucast_rst", ucast_addr, 48'h0);

        // Fresh frame with reset defaults, d=100
        push_frame(64'hFFFF_FFFF_5002_0000, 64, 64);
        wr(8'h1C, 32'h2);
        arm_frame(100);
        e = last_acc;
        wait_until(e + 12800);
        rd(8'h28, 32'h1, "t6_busy_late");
        rd(8'h28, 32'h0, "t6_busy_done");
        check("t6_oe_after", mdio_oe, 1'b0);
        check("t6_bits_left", mq_oe.size(), 0);

        repeat (4) @(negedge wb_clk);
        check("sb_drained", sb_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gemac_wb_regs.md
Name: gemac_wb_regs

Overview:
Wishbone classic slave that holds the GEMAC configuration registers and runs the MDIO management master. It answers single-word bus writes/reads from the host or bench, drives the static filter and pause settings into the MAC core, and serialises MDIO read and write frames to the PHY. It sits in the simple_gemac_wrapper wb_clk domain. The MAC core handles the CDC of its static outputs.

Parameters:
MDIO_DIV_RST, 8'd100, reset value of the MDC divider field.

Ports:
wb_clk  in  1  bus and MDIO clock
wb_rst_n  in  1  asynchronous active-low reset
wb_stb  in  1  strobe
wb_cyc  in  1  cycle
wb_we  in  1  write enable
wb_adr  in  8  byte address; [1:0] ignored
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_ack  out  1  acknowledge
misc_settings  out  7  {pause_request_en, pass_ucast, pass_mcast, pass_bcast, pass_pause, pass_all, pause_respect_en}
ucast_addr  out  48  {ucast_h[15:0], ucast_l[31:0]}
mcast_addr  out  48  {mcast_h[15:0], mcast_l[31:0]}
mdc  out  1  MDIO clock
mdio_o  out  1  MDIO data out
mdio_oe  out  1  MDIO output enable
mdio_i  in  1  MDIO data in

Behaviour:
- Reset: all registers 0 except div=MDIO_DIV_RST. wb_ack=0, wb_dat_o=0, mdc=0, mdio_o=0, mdio_oe=0, FSM=IDLE, busy=0.
- Bus: wb_ack <= wb_stb & wb_cyc & ~wb_ack. One-cycle ack, one wait state, no back-to-back ack.
- Writes take effect at the edge that raises ack. wb_dat_o loads the addressed register at the same edge.
- Register map. Unused upper bits read 0.
  - 0x00 misc[6:0] RW
  - 0x04 ucast_h[15:0] RW
  - 0x08 ucast_l RW
  - 0x0C mcast_h[15:0] RW
  - 0x10 mcast_l RW
  - 0x14 {nopre[8], div[7:0]} RW
  - 0x18 {reg[12:8], phy[4:0]} RW
  - 0x1C cmd WO, reads 0: bit0 = read, bit1 = write, bit0 wins if both set
  - 0x20 wdata[15:0] RW
  - 0x24 rdata[15:0] RO
  - 0x28 {busy[0]} RO
- Unmapped addresses read 0 and ignore writes. Writes to RO registers are ignored.
- Cmd write while busy=1 is ignored. Cmd write with both bits 0 does nothing.
- MDC:
  - Effective divider d = max(div,2).
  - The counter toggles mdc every d wb_clk cycles while the FSM is not in IDLE, giving period 2d.
  - mdc is held low in IDLE.
  - mdio_o/mdio_oe change only on the edge that drives mdc low.
  - mdio_i is sampled on the edge that drives mdc high.
- A cmd accepted at ack edge E sets busy=1 at E, loads the shift register and enters PRE, or HDR if nopre=1.
- FSM sequence: IDLE -> PRE -> HDR -> TA -> DATA -> IDLE. Each bit is one MDC period.
  - PRE: 32 bits of 1, mdio_oe=1.
  - HDR: 14 bits = 01, op (01 write, 10 read), phy[4:0] MSB first, reg[4:0] MSB first.
  - TA: write drives 1 then 0. Read sets mdio_oe=0 for 2 bits.
  - DATA: 16 bits MSB first. Write drives wdata. Read keeps oe=0 and shifts mdio_i in.
- Frame end:
  - At the falling edge ending the last DATA bit: mdio_oe=0, busy=0, FSM=IDLE.
  - On a read, rdata is updated at the same edge.
  - busy lasts exactly 64·2d cycles (32·2d with nopre).
- Config register writes during a frame take effect immediately, but the frame uses the values latched at cmd accept.
- Reset mid-frame aborts at once to reset values. rdata keeps its reset value 0.

Test Plan:
1. Release reset, read every address 0x00–0x28 -> all 0 except 0x14=0x064. wb_ack high for exactly one cycle, two cycles after stb.
2. Write 0x00=0x3D, 0x04=0xA0B0, 0x08=0xC0D0A1B1, then read back -> same values. misc_settings=7'h3D, ucast_addr=48'hA0B0_C0D0A1B1. Write/read 0x3C -> read 0, no output change.
3. Setup: div=2, nopre=0, phy=5'h01, reg=5'h00, wdata=0x1234, cmd=2.
   Required response:
   - busy=1 for 256 cycles.
   - mdio_o sequence: 32×1, 0101, 00001, 00000, 10, 0x1234 MSB first.
   - mdc period 4 cycles.
   - oe low after.
4. Setup: div=8, nopre=1, cmd=1, bench PHY drives mdio_i=0xBEEF after TA.
   Required response:
   - mdio_oe=0 from TA on.
   - busy 512 cycles.
   - rdata reads 0xBEEF.
5. Issue cmd=2 while busy -> ignored, frame bits unchanged, no second frame. Write div=3 mid-frame -> current frame keeps div=2.
6. Assert wb_rst_n low mid-DATA -> mdc=0, mdio_oe=0, busy=0, registers back to reset values. A new cmd after release runs a complete frame.
